// File: rtl/game_tick_timer_if.sv
// IOBUS view of the game tick timer: MCU address/data/strobe in,
// read data, window select and interrupt pulse back.
interface game_tick_timer_if;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] RD_DATA;
  logic        SEL;
  logic        INTR;

  modport master (
    output IOBUS_ADDR, IOBUS_OUT, IOBUS_WR,
    input  RD_DATA, SEL, INTR
  );

  modport slave (
    input  IOBUS_ADDR, IOBUS_OUT, IOBUS_WR,
    output RD_DATA, SEL, INTR
  );
endinterface

// File: rtl/game_tick_timer.sv
// Programmable tick timer on the OTTER IOBUS: counts CLK cycles up to a
// software terminal count and emits a fixed-width INTR pulse per event.
module game_tick_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h1100_0300,
  parameter int          PULSE_LEN = 2
) (
  input logic         CLK,
  input logic         RST,
  game_tick_timer_if.slave bus
);
  localparam int PW = $clog2(PULSE_LEN + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, stateNxt;
  logic          en, enNxt;
  logic          oneshot, oneshotNxt;
  logic [31:0]   term, termNxt;
  logic [31:0]   count, countNxt;
  logic          pend, pendNxt;
  logic          ovr, ovrNxt;
  logic [PW-1:0] pulse, pulseNxt;
  logic          intrQ;

  logic        hit, wrCtrl, wrTerm, wrStat;
  logic [31:0] termEff;
  logic        termEvt;
  logic        unusedAddrBits;

  assign unusedAddrBits = ^bus.IOBUS_ADDR[1:0];

  assign hit    = (bus.IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
  assign wrCtrl = bus.IOBUS_WR && hit && (bus.IOBUS_ADDR[3:2] == 2'd0);
  assign wrTerm = bus.IOBUS_WR && hit && (bus.IOBUS_ADDR[3:2] == 2'd1);
  assign wrStat = bus.IOBUS_WR && hit && (bus.IOBUS_ADDR[3:2] == 2'd3);

  assign termEff = (term == 32'd0) ? 32'd1 : term;
  // A CTRL write in the same cycle takes precedence over the terminal event.
  assign termEvt = (state == RUN) && !wrCtrl && (count >= termEff - 32'd1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      en      <= 1'b0;
      oneshot <= 1'b0;
      term    <= '0;
      count   <= '0;
      pend    <= 1'b0;
      ovr     <= 1'b0;
      pulse   <= '0;
      intrQ   <= 1'b0;
    end else begin
      state   <= stateNxt;
      en      <= enNxt;
      oneshot <= oneshotNxt;
      term    <= termNxt;
      count   <= countNxt;
      pend    <= pendNxt;
      ovr     <= ovrNxt;
      pulse   <= pulseNxt;
      intrQ   <= (pulseNxt != '0);
    end
  end

  always_comb begin
    stateNxt   = state;
    enNxt      = en;
    oneshotNxt = oneshot;
    termNxt    = wrTerm ? bus.IOBUS_OUT : term;
    countNxt   = count;
    pulseNxt   = (pulse != '0) ? pulse - PW'(1) : '0;

    // W1C first, then the event set so a same-cycle event wins.
    pendNxt = pend & ~(wrStat & bus.IOBUS_OUT[0]);
    ovrNxt  = ovr  & ~(wrStat & bus.IOBUS_OUT[1]);
    if (termEvt) begin
      pendNxt = 1'b1;
      ovrNxt  = ovrNxt | pend;
    end

    if (wrCtrl) begin
      enNxt      = bus.IOBUS_OUT[0];
      oneshotNxt = bus.IOBUS_OUT[1];
    end

    case (state)
      IDLE: begin
        if (wrCtrl && bus.IOBUS_OUT[0]) begin
          countNxt = '0;
          stateNxt = RUN;
        end
      end
      RUN: begin
        if (wrCtrl) begin
          if (bus.IOBUS_OUT[0]) begin
            countNxt = '0;
          end else begin
            stateNxt = IDLE;
            pulseNxt = '0;
          end
        end else if (termEvt) begin
          countNxt = '0;
          pulseNxt = PW'(PULSE_LEN);
          if (oneshot) begin
            enNxt    = 1'b0;
            stateNxt = IDLE;
          end
        end else begin
          countNxt = count + 32'd1;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_comb begin
    bus.RD_DATA = '0;
    if (hit) begin
      case (bus.IOBUS_ADDR[3:2])
        2'd0:    bus.RD_DATA = {30'd0, oneshot, en};
        2'd1:    bus.RD_DATA = term;
        2'd2:    bus.RD_DATA = count;
        default: bus.RD_DATA = {30'd0, ovr, pend};
      endcase
    end
  end

  assign bus.SEL  = hit;
  assign bus.INTR = intrQ;
endmodule

// File: tb/tb_game_tick_timer.sv
// Scoreboarded bench for game_tick_timer: directed scenarios plus random
// IOBUS traffic against a behavioural timer model.
module tb_game_tick_timer;
  localparam logic [31:0] BASE = 32'h1100_0300;
  localparam int          PL   = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  game_tick_timer_if bus();

  game_tick_timer #(.BASE_ADDR(BASE), .PULSE_LEN(PL)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus.slave)
  );

  typedef struct {
    logic [31:0] rd;
    logic        sel;
    logic        intr;
    logic [31:0] addr;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;
  logic done   = 1'b0;

  // Behavioural model of the timer as software sees it.
  bit          mEn, mOs, mRun, mPend, mOvr;
  logic [31:0] mTerm, mCount;
  int          mPulseLeft;

  task automatic modelReset();
    mEn = 0; mOs = 0; mRun = 0; mPend = 0; mOvr = 0;
    mTerm = 0; mCount = 0; mPulseLeft = 0;
  endtask

  task automatic modelStep();
    bit              inWin, ctrlWr, fire, oldPend;
    int              reg_, nextPulse;
    longint unsigned eff, cnt;
    logic [31:0]     d;
    if (RST) begin
      modelReset();
      return;
    end
    d      = bus.IOBUS_OUT;
    inWin  = (bus.IOBUS_ADDR >> 4) == (BASE >> 4);
    reg_   = int'(bus.IOBUS_ADDR[3:2]);
    ctrlWr = bus.IOBUS_WR && inWin && reg_ == 0;
    eff    = (mTerm == 0) ? 64'd1 : {32'd0, mTerm};
    cnt    = {32'd0, mCount};
    fire   = mRun && !ctrlWr && (cnt + 1 >= eff);
    nextPulse = (mPulseLeft > 0) ? mPulseLeft - 1 : 0;
    oldPend   = mPend;

    if (ctrlWr) begin
      mEn = d[0]; mOs = d[1];
      if (d[0]) begin
        mCount = 0; mRun = 1;
      end else begin
        if (mRun) nextPulse = 0;
        mRun = 0;
      end
    end else if (mRun) begin
      if (fire) begin
        mCount = 0;
        nextPulse = PL;
        if (mOs) begin mEn = 0; mRun = 0; end
      end else begin
        mCount = mCount + 1;
      end
    end

    if (bus.IOBUS_WR && inWin && reg_ == 3) begin
      if (d[0]) mPend = 0;
      if (d[1]) mOvr = 0;
    end
    if (fire) begin
      if (oldPend) mOvr = 1;
      mPend = 1;
    end
    if (bus.IOBUS_WR && inWin && reg_ == 1) mTerm = d;
    mPulseLeft = nextPulse;
  endtask

  function automatic exp_t expected();
    exp_t e;
    e.addr = bus.IOBUS_ADDR;
    e.sel  = (bus.IOBUS_ADDR >> 4) == (BASE >> 4);
    e.intr = (mPulseLeft > 0);
    e.rd   = 0;
    if (e.sel) begin
      case (bus.IOBUS_ADDR[3:2])
        2'd0:    e.rd = {30'd0, mOs, mEn};
        2'd1:    e.rd = mTerm;
        2'd2:    e.rd = mCount;
        default: e.rd = {30'd0, mOvr, mPend};
      endcase
    end
    return e;
  endfunction

  // One bus cycle: the model consumes the inputs seen at the edge, then new
  // inputs are applied between edges and the expected response is queued.
  task automatic cyc(input logic [31:0] a, input logic [31:0] d,
                     input logic w, input logic r);
    @(posedge CLK);
    modelStep();
    #2;
    RST = r;
    bus.IOBUS_ADDR = a;
    bus.IOBUS_OUT  = d;
    bus.IOBUS_WR   = w;
    if (r) modelReset();
    q.push_back(expected());
  endtask

  task automatic rdr(input logic [3:0] off, input int n);
    for (int i = 0; i < n; i++) cyc(BASE + {28'd0, off}, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic wrr(input logic [3:0] off, input logic [31:0] d);
    cyc(BASE + {28'd0, off}, d, 1'b1, 1'b0);
  endtask

  // Monitor: compares each queued expectation against the live outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks += 3;
        if (bus.INTR !== e.intr) begin
          fails++;
          $display("FAIL intr @%0t addr=%h got=%b want=%b", $time, e.addr, bus.INTR, e.intr);
        end
        if (bus.SEL !== e.sel) begin
          fails++;
          $display("FAIL sel @%0t addr=%h got=%b want=%b", $time, e.addr, bus.SEL, e.sel);
        end
        if (bus.RD_DATA !== e.rd) begin
          fails++;
          $display("FAIL rdata @%0t addr=%h got=%h want=%h", $time, e.addr, bus.RD_DATA, e.rd);
        end
      end
    end
  end

  initial begin
    bus.IOBUS_ADDR = 0;
    bus.IOBUS_OUT  = 0;
    bus.IOBUS_WR   = 0;
    modelReset();

    // Reset and readback
    cyc(BASE, 0, 0, 1);
    cyc(BASE, 0, 0, 1);
    rdr(4'h0, 1); rdr(4'h4, 1); rdr(4'h8, 1); rdr(4'hC, 1);
    wrr(4'h4, 32'd5);
    rdr(4'h4, 1);
    cyc(BASE + 32'h10, 0, 0, 0);
    cyc(BASE + 32'h7, 0, 0, 0);

    // Periodic tick, PEND set and cleared
    wrr(4'h4, 32'd4);
    wrr(4'h0, 32'd1);
    rdr(4'hC, 14);
    wrr(4'hC, 32'd1);
    rdr(4'hC, 2);

    // Overrun, then clear landing on the terminal-event cycle
    wrr(4'h0, 32'd0);
    wrr(4'hC, 32'd3);
    wrr(4'h4, 32'd3);
    wrr(4'h0, 32'd1);
    rdr(4'hC, 8);
    wrr(4'hC, 32'd3);
    wrr(4'h0, 32'd1);
    rdr(4'h8, 2);
    wrr(4'hC, 32'd1);
    rdr(4'hC, 3);

    // One-shot
    wrr(4'h0, 32'd0);
    wrr(4'hC, 32'd3);
    wrr(4'h4, 32'd10);
    wrr(4'h0, 32'd3);
    rdr(4'h8, 15);
    rdr(4'h0, 1);
    rdr(4'h8, 50);

    // TERM 0 and 1: continuous INTR
    wrr(4'h4, 32'd0);
    wrr(4'h0, 32'd1);
    rdr(4'h8, 6);
    wrr(4'h4, 32'd1);
    rdr(4'hC, 6);
    wrr(4'h0, 32'd0);
    rdr(4'h8, 3);

    // Lowering TERM below COUNT
    wrr(4'h4, 32'd100);
    wrr(4'h0, 32'd1);
    rdr(4'h8, 20);
    wrr(4'h4, 32'd8);
    rdr(4'h8, 4);

    // Disable mid-pulse
    wrr(4'h4, 32'd3);
    wrr(4'h0, 32'd1);
    rdr(4'h8, 3);
    wrr(4'h0, 32'd0);
    rdr(4'h8, 3);

    // Async reset during a pulse
    wrr(4'h0, 32'd1);
    rdr(4'h8, 4);
    cyc(BASE + 32'h8, 0, 0, 1);
    cyc(BASE + 32'hC, 0, 0, 1);
    rdr(4'h0, 1);

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      logic [31:0] a, d;
      logic        w, r;
      int          k;
      k = $urandom_range(0, 99);
      a = BASE + {28'd0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 19) == 0) a = $urandom;
      w = (k < 20);
      r = ($urandom_range(0, 599) == 0);
      d = (a[3:2] == 2'd1) ? 32'($urandom_range(0, 12)) : 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) d = $urandom;
      cyc(a, d, w, r);
    end

    @(posedge CLK);
    #2 bus.IOBUS_WR = 0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge CLK);
    if (q.size() > 0) begin
      fails++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/game_tick_timer.md
Name: game_tick_timer

Overview:
- Memory-mapped programmable tick timer on the OTTER IOBUS.
- Software sets a terminal count. The timer counts CLK cycles and drives the MCU INTR input with a fixed-width pulse at each terminal event.
- This pulse is the snake game's movement tick. Pending and overrun status are readable and cleared by software.
- IOBUS_OUT, IOBUS_ADDR and IOBUS_WR from otter_mcu feed it. Its RD_DATA goes into the top-level IOBUS_IN read mux.

Parameters:
- BASE_ADDR, 32'h1100_0300, word-aligned base of the 4-register window.
- PULSE_LEN, 2, INTR high time in CLK cycles (≥1). It covers the MCU's multi-cycle interrupt sample point.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous active-high reset.
- IOBUS_ADDR  input  32  MCU I/O address.
- IOBUS_OUT  input  32  MCU write data.
- IOBUS_WR  input  1  MCU write strobe, one cycle per store.
- RD_DATA  output  32  combinational read data for the addressed register; 0 when the address is outside the window.
- SEL  output  1  high when IOBUS_ADDR hits the window; steers the top-level IOBUS_IN mux.
- INTR  output  1  interrupt pulse to otter_mcu.

Behaviour:
- One clock. Reset is asynchronous and active-high. Clock port is CLK, reset port is RST.
- Register map (word offsets):
  - +0x0 CTRL (RW): bit0 EN, bit1 ONESHOT; other bits read 0.
  - +0x4 TERM (RW, 32b).
  - +0x8 COUNT (RO).
  - +0xC STATUS: bit0 PEND, bit1 OVR; write-1-to-clear.
- Write decode: a register is written only when IOBUS_WR=1 and IOBUS_ADDR[31:4]=BASE_ADDR[31:4]. IOBUS_ADDR[3:2] selects the register; IOBUS_ADDR[1:0] is ignored. Writes to COUNT are ignored.
- Reset values: CTRL=0, TERM=0, COUNT=0, PEND=0, OVR=0, INTR=0, state=IDLE, pulse counter=0.
- TERM effective value: TERM_EFF = (TERM==0) ? 1 : TERM.
- State machine:
  - IDLE: COUNT holds. A CTRL write with EN=1 clears COUNT to 0 and moves to RUN on the next edge.
  - RUN: COUNT increments by 1 every cycle.
  - Terminal event: in RUN with COUNT ≥ TERM_EFF−1, on that edge:
    - COUNT←0.
    - PEND←1.
    - OVR←1 if PEND was already 1.
    - Pulse counter←PULSE_LEN.
    - If ONESHOT=1: EN←0 and state←IDLE. Otherwise stay in RUN.
  - The ≥ compare means lowering TERM below the current COUNT fires on the next cycle instead of wrapping through 2^32.
- RUN exits:
  - A CTRL write with EN=0: state←IDLE next edge, COUNT held, pulse counter←0. An in-flight INTR drops on the next cycle.
  - A CTRL write with EN=1 while in RUN restarts: COUNT←0.
- INTR is registered: INTR=1 while pulse counter≠0. The pulse counter decrements each cycle.
- A new terminal event during a pulse reloads the counter to PULSE_LEN, so INTR stays high continuously. With TERM_EFF=1 and ONESHOT=0, INTR is high every cycle.
- Terminal event and a STATUS W1C in the same cycle: the set wins. PEND stays 1, and OVR follows the pre-clear PEND.
- TERM written during RUN takes effect on the next compare. COUNT is not reset.
- Reading has no side effects. RD_DATA and SEL are purely combinational from IOBUS_ADDR and register state.
- RST asserted mid-run or mid-pulse: all state returns to reset values immediately; INTR drops asynchronously.

Test Plan:
- Reset/readback: RST high 20ns then low → INTR=0, RD_DATA=0 at all four offsets. Write TERM=32'd5 → read +0x4 returns 5. Read address BASE+0x10 → SEL=0, RD_DATA=0.
- Periodic tick: TERM=4, CTRL=1 → INTR rises on the edge ending every 4th RUN cycle and stays high exactly 2 cycles. PEND=1 after the first event. Writing STATUS=1 clears PEND.
- Overrun and priority: TERM=3, CTRL=1, no clear → OVR=1 after the second event. Write STATUS=1 on the exact terminal-event cycle → PEND still reads 1.
- One-shot: TERM=10, CTRL=3 → exactly one 2-cycle INTR pulse, then CTRL reads 2, state IDLE, COUNT=0 held for 50 cycles.
- Edge cases:
  - TERM=0 or TERM=1 with CTRL=1 → INTR continuously high.
  - COUNT=20 with TERM lowered to 8 → event on the next cycle.
  - CTRL=0 written mid-pulse → INTR low next cycle.
- Async reset: assert RST between clock edges during a pulse with COUNT=7 → INTR, COUNT, PEND are 0 before the next CLK edge.
